sram_arbiter: RTL
=================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have one parameter: ACCESS_CYCLES, default 2, legal range 2..15, number of clocks per SRAM access phase.
REQ-002 The block SHALL have the following ports, clock and reset first:
- clk  in  1  system clock (50 MHz), the only clock.
- reset  in  1  asynchronous, active-high reset.
- a_req  in  1  display port read request.
- a_addr  in  18  display port word address.
- a_rdata  out  16  display port read data.
- a_valid  out  1  one-cycle pulse; a_rdata is valid.
- b_req  in  1  CPU port request.
- b_we  in  1  CPU port write when 1, read when 0.
- b_addr  in  18  CPU port word address.
- b_be  in  2  CPU write byte enables, [1]=upper, [0]=lower.
- b_wdata  in  16  CPU write data.
- b_rdata  out  16  CPU read data.
- b_done  out  1  one-cycle pulse; CPU access complete.
- SRAM_ADDR  out  18  SRAM address.
- SRAM_DQ  inout  16  SRAM data.
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  SRAM controls, active-low.

Function
REQ-003 The state machine SHALL have three states: IDLE, ACCESS, DONE.
REQ-004 In IDLE with at least one request, the block SHALL grant a port, register its address, data, we and be, and move to ACCESS at the next edge.
REQ-005 If only one port requests, that port SHALL be granted.
REQ-006 If both ports request in the same cycle, the port not served last SHALL be granted (round-robin).
REQ-007 The last-served pointer SHALL reset to B, so port A wins the first tie.
REQ-008 ACCESS SHALL last exactly ACCESS_CYCLES cycles, timed by a 4-bit counter; it SHALL then move to DONE.
REQ-009 DONE SHALL last exactly 1 cycle and SHALL then move to IDLE.
REQ-010 In DONE, a_valid or b_done SHALL be high for the granted port only; it SHALL be low in every other cycle.
REQ-011 Latency and throughput: the pulse SHALL appear ACCESS_CYCLES+1 cycles after the grant edge; one access SHALL complete every ACCESS_CYCLES+2 cycles.
REQ-012 Read access: during all ACCESS cycles, CE_N=0, OE_N=0, WE_N=1, UB_N=0, LB_N=0, DQ=Z.
REQ-013 Read data SHALL be sampled from SRAM_DQ at the edge ending the last ACCESS cycle, into a_rdata or b_rdata.
REQ-014 a_rdata and b_rdata SHALL hold their value until the next read on the same port.
REQ-015 Write access (port B, b_we=1): CE_N=0, OE_N=1, DQ driven with wdata, UB_N=~be[1], LB_N=~be[0] during all ACCESS cycles.
REQ-016 WE_N SHALL be 0 in all ACCESS cycles except the last, where it SHALL be 1 (data hold).
REQ-017 Port A SHALL be read-only.
REQ-018 b_be SHALL be ignored on reads.
REQ-019 A write with b_be=00 SHALL still complete and pulse b_done, with both UB_N and LB_N high.
REQ-020 In IDLE and DONE, SRAM controls SHALL be all 1 and DQ SHALL be Z.
REQ-021 SRAM_ADDR SHALL hold the last registered address.
REQ-022 All SRAM outputs SHALL be driven from registers.
REQ-023 Requesters SHALL hold req and request fields stable until their pulse, and SHALL deassert req at the edge ending DONE.
REQ-024 Request-field changes while not granted SHALL have no effect.
REQ-025 A request raised during ACCESS or DONE SHALL be considered at the next IDLE.
REQ-026 Address wrap: 0x3FFFF SHALL be a legal address; there is no address arithmetic.

Reset
REQ-027 While reset=1, the block SHALL be in IDLE with: SRAM controls all 1, SRAM_ADDR=0, DQ=Z, a_valid=0, b_done=0, a_rdata=0, b_rdata=0, counter=0, pointer=B.
REQ-028 Reset asserted mid-ACCESS SHALL abort the access immediately (asynchronously), with no done or valid pulse and no completed write guaranteed.
REQ-029 After reset is released, the first active edge SHALL evaluate requests from IDLE.

Structure
REQ-030 A shared package sram_arb_pkg SHALL hold the state enum and the constants SRAM_AW=18 and SRAM_DW=16.
REQ-031 One sub-module, sram_arb_rr (the 2-way round-robin grant picker with last-served pointer), SHALL be used; all other logic SHALL be in sram_arbiter.
REQ-032 The DQ tristate SHALL be implemented in sram_arbiter using a registered output-enable.

Verification (ACCESS_CYCLES=2, SRAM behavioural model)
REQ-033 Reset idle: release reset with no requests -> CE_N/OE_N/WE_N/UB_N/LB_N=1, DQ=Z, a_valid=b_done=0 for 10 cycles.
REQ-034 CPU write: b_req, b_we=1, addr 0x00010, data 0xBEEF, be=11 -> WE_N low 1 cycle, DQ=0xBEEF for 2 cycles, b_done 3 cycles after grant, model word 0x00010=0xBEEF.
REQ-035 Display read: preload 0x3FFFF=0x1234, a_req -> a_valid 3 cycles after grant with a_rdata=0x1234.
REQ-036 Contention: a_req and b_req held continuously from reset -> grants A,B,A,B, one pulse every 4 cycles.
REQ-037 Byte write: preload 0x00020=0xAAAA, write 0x5555 with be=10 -> UB_N=0, LB_N=1, model=0x55AA; CPU read-back b_rdata=0x55AA.
REQ-038 Reset mid-access: assert reset in the first ACCESS cycle of a read -> controls all 1 and DQ=Z that cycle, no pulse; after release, a held request is served normally.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared widths, FSM states and port ids for the SRAM arbiter.
package sram_arb_pkg;
  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic {PORT_A, PORT_B} port_t;
endpackage

// File: rtl/sram_arb_rr.sv
// sram_arb_rr: 2-way round-robin grant picker with a last-served pointer.
module sram_arb_rr
  import sram_arb_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  a_req,
  input  logic  b_req,
  input  logic  update,
  output port_t grant
);
  port_t last;
  always_comb grant = (a_req && (!b_req || last == PORT_B)) ? PORT_A : PORT_B;
  always_ff @(posedge clk or posedge reset)
    if (reset) last <= PORT_B;
    else if (update) last <= grant;
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: arbitrates a read-only display port and a read/write CPU port
// onto one asynchronous SRAM with fixed-length, fully registered access phases.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               a_req,
  input  logic [SRAM_AW-1:0] a_addr,
  output logic [SRAM_DW-1:0] a_rdata,
  output logic               a_valid,
  input  logic               b_req,
  input  logic               b_we,
  input  logic [SRAM_AW-1:0] b_addr,
  input  logic [1:0]         b_be,
  input  logic [SRAM_DW-1:0] b_wdata,
  output logic [SRAM_DW-1:0] b_rdata,
  output logic               b_done,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  inout  logic [SRAM_DW-1:0] SRAM_DQ,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_WE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
);
  state_t state, next_state;
  port_t grant, sel;
  logic [3:0] cnt;
  logic [SRAM_DW-1:0] wdata;
  logic oe, take, wr, last_cyc;
  sram_arb_rr u_rr (
    .clk(clk),
    .reset(reset),
    .a_req(a_req),
    .b_req(b_req),
    .update(take),
    .grant(grant)
  );
  always_comb begin
    take = state == IDLE && (a_req || b_req);
    wr = grant == PORT_B && b_we;
    last_cyc = state == ACCESS && cnt == 4'(ACCESS_CYCLES - 1);
    next_state = state == IDLE ? (take ? ACCESS : IDLE) :
                 state == ACCESS ? (last_cyc ? DONE : ACCESS) : IDLE;
  end
  assign SRAM_DQ = oe ? wdata : 'z;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      sel <= PORT_A;
      cnt <= '0;
      wdata <= '0;
      oe <= 1'b0;
      a_valid <= 1'b0;
      b_done <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
      SRAM_ADDR <= '0;
      {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N} <= '1;
    end else begin
      state <= next_state;
      a_valid <= 1'b0;
      b_done <= 1'b0;
      if (take) begin
        sel <= grant;
        cnt <= '0;
        wdata <= b_wdata;
        oe <= wr;
        SRAM_ADDR <= grant == PORT_A ? a_addr : b_addr;
        SRAM_CE_N <= 1'b0;
        SRAM_OE_N <= wr;
        SRAM_WE_N <= !wr;
        SRAM_UB_N <= wr && !b_be[1];
        SRAM_LB_N <= wr && !b_be[0];
      end else if (state == ACCESS) begin
        cnt <= last_cyc ? 4'd0 : cnt + 4'd1;
        // Release WE_N one cycle early so data is held past the write strobe.
        if (cnt == 4'(ACCESS_CYCLES - 2)) SRAM_WE_N <= 1'b1;
        if (last_cyc) begin
          oe <= 1'b0;
          {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N} <= '1;
          a_valid <= sel == PORT_A;
          b_done <= sel == PORT_B;
          if (!SRAM_OE_N && sel == PORT_A) a_rdata <= SRAM_DQ;
          if (!SRAM_OE_N && sel == PORT_B) b_rdata <= SRAM_DQ;
        end
      end
    end
endmodule
